// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU among NREQ issuers.
// Round-robin grant in IDLE, operands latched on handshake and driven to the
// ALU from registers during EXEC, result captured and returned in RESP with a
// valid/ready handshake. Only one operation is ever in flight.
module alu_share_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_ctrl,
  input  logic [WIDTH-1:0]      alu_s,
  input  logic                  alu_zero,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_id,
  output logic [WIDTH-1:0]      resp_s,
  output logic                  resp_zero
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [1:0]         r_last;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [2:0]         r_op;
  logic [1:0]         r_id;
  logic               r_resp_valid;
  logic [WIDTH-1:0]   r_resp_s;
  logic               r_resp_zero;

  // Distance of each requester from the round-robin pointer: 0 is the one
  // right after the last winner, so the smallest distance among valid
  // requesters is the grant. Distances are all distinct.
  logic [1:0]         w_dist [NREQ];
  logic [NREQ-1:0]    w_win;
  logic               w_any;
  logic               w_hs;

  // OR-accumulation chains turning the one-hot winner into a selected
  // operand set without variable-index part selects.
  logic [WIDTH-1:0]   w_a_acc  [NREQ+1];
  logic [WIDTH-1:0]   w_b_acc  [NREQ+1];
  logic [2:0]         w_op_acc [NREQ+1];
  logic [1:0]         w_id_acc [NREQ+1];

  assign w_a_acc[0]  = '0;
  assign w_b_acc[0]  = '0;
  assign w_op_acc[0] = '0;
  assign w_id_acc[0] = '0;

  genvar gi, gj;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      logic [NREQ-1:0] w_beat;

      assign w_dist[gi] = 2'((gi + 2 * NREQ - 1 - int'(r_last)) % NREQ);

      // A requester loses if any other valid requester sits closer to the pointer.
      for (gj = 0; gj < NREQ; gj++) begin : g_cmp
        assign w_beat[gj] = req_valid[gj] && (w_dist[gj] < w_dist[gi]);
      end

      assign w_win[gi] = req_valid[gi] && !(|w_beat);

      assign w_a_acc[gi+1]  = w_a_acc[gi]  | (req_a[gi*WIDTH +: WIDTH] & {WIDTH{w_win[gi]}});
      assign w_b_acc[gi+1]  = w_b_acc[gi]  | (req_b[gi*WIDTH +: WIDTH] & {WIDTH{w_win[gi]}});
      assign w_op_acc[gi+1] = w_op_acc[gi] | (req_op[gi*3 +: 3] & {3{w_win[gi]}});
      assign w_id_acc[gi+1] = w_id_acc[gi] | (2'(gi) & {2{w_win[gi]}});
    end
  endgenerate

  assign w_any = |req_valid;
  assign w_hs  = (r_state == S_IDLE) && w_any;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> EXEC on a grant, EXEC always one cycle, RESP until accepted.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_next = S_EXEC;
      S_EXEC:  w_state_next = S_RESP;
      S_RESP:  if (resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: the grant is only offered while idle; w_win is zero when nobody is valid.
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE) req_ready = w_win;
  end

  // Operand, owner and round-robin pointer latching on the request handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_op   <= 3'b000;
      r_id   <= 2'd0;
      r_last <= 2'(NREQ - 1);
    end else if (w_hs) begin
      r_a    <= w_a_acc[NREQ];
      r_b    <= w_b_acc[NREQ];
      r_op   <= w_op_acc[NREQ];
      r_id   <= w_id_acc[NREQ];
      r_last <= w_id_acc[NREQ];
    end
  end

  // Result capture at the end of EXEC and response handshake release in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_s     <= '0;
      r_resp_zero  <= 1'b0;
    end else if (r_state == S_EXEC) begin
      r_resp_valid <= 1'b1;
      r_resp_s     <= alu_s;
      r_resp_zero  <= alu_zero;
    end else if ((r_state == S_RESP) && resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  // ALU inputs come straight from registers so they never glitch with requester inputs.
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_ctrl   = r_op;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_s     = r_resp_s;
  assign resp_zero  = r_resp_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed vector table, backpressure,
// reset-abort and contention sequences, then a long random run against a
// scoreboard and a cycle model of the arbiter handshake.
module tb_alu_share_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [W-1:0]      alu_a;
  logic [W-1:0]      alu_b;
  logic [2:0]        alu_ctrl;
  logic [W-1:0]      alu_s;
  logic              alu_zero;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_id;
  logic [W-1:0]      resp_s;
  logic              resp_zero;

  logic [W-1:0] opa [NREQ];
  logic [W-1:0] opb [NREQ];
  logic [2:0]   opc [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[gi*W +: W] = opa[gi];
    assign req_b[gi*W +: W] = opb[gi];
    assign req_op[gi*3 +: 3] = opc[gi];
  end

  alu_share_arbiter #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_s(alu_s), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_s(resp_s), .resp_zero(resp_zero)
  );

  always #5 clk = ~clk;

  // Reference ALU: also serves as the shared ALU the arbiter drives.
  function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return '0;
    endcase
  endfunction

  assign alu_s    = ref_alu(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_s == '0);

  typedef struct {
    int         id;
    logic [W-1:0] s;
    logic       z;
  } exp_t;

  typedef struct {
    int         r;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0] op;
    logic [W-1:0] s;
    logic       z;
  } vec_t;

  exp_t sb[$];
  vec_t vt[11];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Compare the presented response with the oldest expected result.
  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_unexpected: actual=resp id %0d s=%0h required=no response", tag, resp_id, resp_s);
    end else begin
      e = sb.pop_front();
      chk({tag, "_id"}, 64'(resp_id), 64'(e.id));
      chk({tag, "_s"}, 64'(resp_s), 64'(e.s));
      chk({tag, "_zero"}, 64'(resp_zero), 64'(e.z));
      $display("%s: resp id=%0d s=%08h zero=%0b (exp id=%0d s=%08h zero=%0b)",
               tag, resp_id, resp_s, resp_zero, e.id, e.s, e.z);
    end
  endtask

  // One isolated operation from requester v.r with resp_ready held high.
  task automatic run_vec(input vec_t v);
    resp_ready = 1'b1;
    opa[v.r] = v.a;
    opb[v.r] = v.b;
    opc[v.r] = v.op;
    req_valid = '0;
    req_valid[v.r] = 1'b1;
    #1;
    chk("vec_grant", 64'(req_ready), 64'(1 << v.r));
    sb.push_back('{v.r, v.s, v.z});
    tick;
    req_valid = '0;
    #1;
    chk("vec_exec_ready", 64'(req_ready), 64'd0);
    chk("vec_exec_rvalid", 64'(resp_valid), 64'd0);
    chk("vec_alu_a", 64'(alu_a), 64'(v.a));
    chk("vec_alu_b", 64'(alu_b), 64'(v.b));
    chk("vec_alu_ctrl", 64'(alu_ctrl), 64'(v.op));
    tick;
    chk("vec_rvalid", 64'(resp_valid), 64'd1);
    pop_check("vec");
    tick;
    chk("vec_idle_rvalid", 64'(resp_valid), 64'd0);
  endtask

  // Random traffic against a cycle model of grant order and handshakes.
  task automatic run_random(input int nops);
    int ph;
    int nph;
    int mlast;
    int g;
    int c;
    int done;
    int cyc;
    int waitcnt [NREQ];
    logic [NREQ-1:0] exp_rdy;
    ph = 0;
    mlast = NREQ - 1;
    done = 0;
    cyc = 0;
    for (int i = 0; i < NREQ; i++) waitcnt[i] = 0;
    while (done < nops && cyc < 90000) begin
      #1;
      g = -1;
      if (ph == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (mlast + k) % NREQ;
          if (g < 0 && req_valid[c]) g = c;
        end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
      chk("rnd_rvalid", 64'(resp_valid), 64'(ph == 2));
      nph = ph;
      if (g >= 0) begin
        for (int i = 0; i < NREQ; i++)
          if (i != g && req_valid[i]) waitcnt[i]++;
        chk("rnd_fair", 64'(waitcnt[g] <= NREQ - 1), 64'd1);
        waitcnt[g] = 0;
        sb.push_back('{g, ref_alu(opa[g], opb[g], opc[g]),
                       ref_alu(opa[g], opb[g], opc[g]) == '0});
        mlast = g;
        nph = 1;
      end else if (ph == 1) begin
        nph = 2;
      end else if (ph == 2 && resp_ready) begin
        pop_check("rnd");
        done++;
        nph = 0;
      end
      tick;
      cyc++;
      ph = nph;
      if (g >= 0) req_valid[g] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(3) != 0) begin
          opa[i] = $urandom_range(1) ? $urandom() : W'($urandom_range(15));
          opb[i] = ($urandom_range(3) == 0) ? opa[i] : $urandom();
          opc[i] = 3'($urandom_range(7));
          req_valid[i] = 1'b1;
        end
      end
      resp_ready = ($urandom_range(3) != 0);
    end
    total++;
    if (done < nops) begin
      bad++;
      $display("FAIL rnd_budget: actual=%0d ops required=%0d ops", done, nops);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ng;
    int gnt;
    vt[0]  = '{0, 32'd7,          32'd5,          3'b010, 32'd12,         1'b0};
    vt[1]  = '{1, 32'd5,          32'd5,          3'b110, 32'd0,          1'b1};
    vt[2]  = '{0, 32'd3,          32'd7,          3'b111, 32'd1,          1'b0};
    vt[3]  = '{1, 32'd7,          32'd3,          3'b111, 32'd0,          1'b1};
    vt[4]  = '{0, 32'hF0F0_0000,  32'h0FF0_00FF,  3'b000, 32'h00F0_0000,  1'b0};
    vt[5]  = '{1, 32'hF000_0000,  32'h0000_000F,  3'b001, 32'hF000_000F,  1'b0};
    vt[6]  = '{0, 32'd1,          32'd2,          3'b110, 32'hFFFF_FFFF,  1'b0};
    vt[7]  = '{1, 32'hFFFF_FFFF,  32'd1,          3'b010, 32'd0,          1'b1};
    vt[8]  = '{0, 32'd9,          32'd9,          3'b100, 32'd0,          1'b1};
    vt[9]  = '{1, 32'hFFFF_FFFE,  32'd3,          3'b111, 32'd1,          1'b0};
    vt[10] = '{1, 32'd6,          32'd3,          3'b101, 32'd0,          1'b1};

    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = '0;
      opb[i] = '0;
      opc[i] = '0;
    end
    tick;
    tick;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_rvalid", 64'(resp_valid), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_resp_s", 64'(resp_s), 64'd0);
    rst = 1'b0;
    tick;

    // Directed vectors (T1, T2 and ALU opcode coverage).
    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // Backpressure: result must hold while resp_ready is low.
    opa[0] = 32'd100; opb[0] = 32'd23; opc[0] = 3'b010;
    req_valid = 2'b01;
    resp_ready = 1'b0;
    #1;
    sb.push_back('{0, 32'd123, 1'b0});
    tick;
    opa[1] = 32'd4; opb[1] = 32'd4; opc[1] = 3'b110;
    req_valid = 2'b10;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("bp_rvalid", 64'(resp_valid), 64'd1);
      chk("bp_s", 64'(resp_s), 64'd123);
      chk("bp_id", 64'(resp_id), 64'd0);
      chk("bp_ready", 64'(req_ready), 64'd0);
      tick;
    end
    resp_ready = 1'b1;
    #1;
    pop_check("bp");
    tick;
    chk("bp_release_rvalid", 64'(resp_valid), 64'd0);
    chk("bp_release_grant", 64'(req_ready), 64'b10);
    sb.push_back('{1, 32'd0, 1'b1});
    tick;
    req_valid = '0;
    tick;
    pop_check("bp2");
    tick;

    // Reset during EXEC aborts the op and restores the pointer.
    opa[0] = 32'd1; opb[0] = 32'd1; opc[0] = 3'b010;
    req_valid = 2'b01;
    tick;
    #1;
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd0);
    chk("abort_alu_a", 64'(alu_a), 64'd0);
    chk("abort_alu_b", 64'(alu_b), 64'd0);
    chk("abort_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("abort_rvalid", 64'(resp_valid), 64'd0);
    chk("abort_id", 64'(resp_id), 64'd0);
    chk("abort_s", 64'(resp_s), 64'd0);
    chk("abort_zero", 64'(resp_zero), 64'd0);
    tick;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_no_resp", 64'(resp_valid), 64'd0);
    end

    // Contention: both requesters held valid, expect alternating grants from req0.
    opa[0] = 32'd10; opb[0] = 32'd1; opc[0] = 3'b110;
    opa[1] = 32'd2;  opb[1] = 32'd3; opc[1] = 3'b000;
    req_valid = 2'b11;
    resp_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 60 && !(ng == 6 && sb.size() == 0); c++) begin
      #1;
      if (req_ready != '0 && ng < 6) begin
        gnt = req_ready[1] ? 1 : 0;
        chk("rr_order", 64'(gnt), 64'(ng % 2));
        $display("rr: grant %0d -> req%0d", ng, gnt);
        sb.push_back('{gnt, (gnt == 0) ? 32'd9 : 32'd2, 1'b0});
        ng++;
      end
      if (resp_valid) pop_check("rr");
      tick;
      if (ng == 6) req_valid = '0;
    end
    total++;
    if (ng != 6 || sb.size() != 0) begin
      bad++;
      $display("FAIL rr_budget: actual=%0d grants %0d pending required=6 grants 0 pending", ng, sb.size());
    end

    // Random traffic from a fresh reset.
    rst = 1'b1;
    req_valid = '0;
    tick;
    rst = 1'b0;
    chk("rnd_rst_rvalid", 64'(resp_valid), 64'd0);
    tick;
    run_random(10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
